// File: rtl/demux_vc_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_pkg
// Description : Shared constants and types for the two-VC source router.
// Revision    : 1.0 - initial release
// ============================================================================
package vc_pkg;

  // Virtual channel indices
  localparam int C_VC0 = 0;
  localparam int C_VC1 = 1;

  // Router FSM encoding
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } vc_state_t;

  // The class bit is the MSB of the data word
  function automatic int class_bit_pos(input int width);
    return width - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_vc_src_vc_hold_slot.sv
`default_nettype none
// ============================================================================
// Module      : vc_hold_slot
// Description : Per-VC one-entry hold register, registered write port to the
//               VC FIFO and a wrapping count of words written.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_hold_slot #(
  parameter int BITNUMBER = 6,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] i_data,
  input  logic                 i_pass,
  input  logic                 i_capture,
  input  logic                 i_drain,
  output logic                 o_full,
  output logic [BITNUMBER-1:0] o_data,
  output logic                 o_valid,
  output logic [CNTWIDTH-1:0]  o_count
);

  logic [BITNUMBER-1:0] r_hold;
  logic                 r_full;
  logic [BITNUMBER-1:0] r_data;
  logic                 r_valid;
  logic [CNTWIDTH-1:0]  r_count;
  logic                 w_write;

  // Pass-through and drain never coincide: a hold is only full while the
  // router is stalled, and nothing is accepted from upstream then.
  assign w_write = i_pass | i_drain;

  // Hold register: filled on capture, emptied when it drains
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      r_full <= 1'b0;
    end else if (i_capture) begin
      r_hold <= i_data;
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  // Output register and counter: one strobe per word written to the FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= w_write;
      if (w_write) begin
        r_data  <= i_pass ? i_data : r_hold;
        r_count <= r_count + CNTWIDTH'(1);
      end
    end
  end

  assign o_full  = r_full;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/demux_vc_src.sv
`default_nettype none
// ============================================================================
// Module      : demux_vc_src
// Description : Source-side VC router. Steers each upstream word into VC0 or
//               VC1 by its class bit, absorbs almost-full backpressure in a
//               per-VC hold slot and pauses upstream while any hold is full.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_vc_src
  import vc_pkg::*;
#(
  parameter int BITNUMBER = 6,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 almost_full_vc0,
  input  logic                 almost_full_vc1,
  output logic [BITNUMBER-1:0] data_out_vc0,
  output logic                 valid_out_vc0,
  output logic [BITNUMBER-1:0] data_out_vc1,
  output logic                 valid_out_vc1,
  output logic                 pause_in,
  output logic [CNTWIDTH-1:0]  count_vc0,
  output logic [CNTWIDTH-1:0]  count_vc1,
  output logic                 error
);

  localparam int C_CLS = class_bit_pos(BITNUMBER);

  vc_state_t            r_state;
  logic                 r_pause;
  logic                 r_error;

  logic                 w_tgt;
  logic                 w_accept;
  logic [1:0]           w_af;
  logic [1:0]           w_sel;
  logic [1:0]           w_pass;
  logic [1:0]           w_capture;
  logic [1:0]           w_drain;
  logic [1:0]           w_full;
  logic [1:0]           w_valid_out;
  logic [BITNUMBER-1:0] w_data_out  [2];
  logic [CNTWIDTH-1:0]  w_count_out [2];
  logic                 w_any_capture;
  logic                 w_all_clear;

  assign w_tgt    = data_in[C_CLS];
  // Only words offered while not paused are accepted; the rest are dropped
  assign w_accept = valid_in & ~r_pause;
  assign w_af     = {almost_full_vc1, almost_full_vc0};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_vc
      assign w_sel[g]     = w_accept & ((g == C_VC1) ? w_tgt : ~w_tgt);
      assign w_pass[g]    = w_sel[g] & ~w_af[g];
      assign w_capture[g] = w_sel[g] &  w_af[g];
      assign w_drain[g]   = w_full[g] & ~w_af[g];

      vc_hold_slot #(
        .BITNUMBER (BITNUMBER),
        .CNTWIDTH  (CNTWIDTH)
      ) u_slot (
        .clk       (clk),
        .reset     (reset),
        .i_data    (data_in),
        .i_pass    (w_pass[g]),
        .i_capture (w_capture[g]),
        .i_drain   (w_drain[g]),
        .o_full    (w_full[g]),
        .o_data    (w_data_out[g]),
        .o_valid   (w_valid_out[g]),
        .o_count   (w_count_out[g])
      );
    end
  endgenerate

  assign w_any_capture = |w_capture;
  // True when every hold is either empty or drains on this edge
  assign w_all_clear   = &(~w_full | w_drain);

  // Stall FSM: pause rises with the capture edge and falls one cycle after
  // the edge on which the last hold drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_pause <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_any_capture) begin
            r_state <= ST_STALL;
            r_pause <= 1'b1;
          end else begin
            r_pause <= 1'b0;
          end
        end
        ST_STALL: begin
          r_pause <= 1'b1;
          if (w_all_clear) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_pause <= 1'b0;
        end
      endcase
    end
  end

  // Sticky protocol-violation flag: a word offered while paused
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_error <= 1'b0;
    end else if (valid_in && r_pause) begin
      r_error <= 1'b1;
    end
  end

  assign data_out_vc0  = w_data_out[C_VC0];
  assign data_out_vc1  = w_data_out[C_VC1];
  assign valid_out_vc0 = w_valid_out[C_VC0];
  assign valid_out_vc1 = w_valid_out[C_VC1];
  assign count_vc0     = w_count_out[C_VC0];
  assign count_vc1     = w_count_out[C_VC1];
  assign pause_in      = r_pause;
  assign error         = r_error;

endmodule
`default_nettype wire
